// File: rtl/cpu_writeback.sv
// Writeback arbiter: three one-entry result slots (ALU, LSU, CSR) sharing the register-file write port.
// Optional commit logging is compiled in when CPU_WB_LOG_EN is defined.
module cpu_writeback #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            csr_valid,
  output logic            csr_ready,
  input  logic [4:0]      csr_rd,
  input  logic [XLEN-1:0] csr_data,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_write_en,
  output logic [31:0]     pending_mask,
  output logic            busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Slot index 0 = ALU, 1 = LSU, 2 = CSR; grant is one-hot over these.
  logic [2:0]      w_valid;
  logic [2:0]      w_ready;
  logic [2:0]      w_gnt;
  logic            w_lsu_forced;
  logic            w_csr_forced;
  logic [4:0]      w_in_rd   [3];
  logic [XLEN-1:0] w_in_data [3];
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [31:0]     w_pend;

  logic [2:0]      r_full;
  logic [4:0]      r_rd   [3];
  logic [XLEN-1:0] r_data [3];
  logic [3:0]      r_lsu_cnt;
  logic [3:0]      r_csr_cnt;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic            r_we;

  assign w_valid      = {csr_valid, lsu_valid, alu_valid};
  assign w_in_rd[0]   = alu_rd;
  assign w_in_rd[1]   = lsu_rd;
  assign w_in_rd[2]   = csr_rd;
  assign w_in_data[0] = alu_data;
  assign w_in_data[1] = lsu_data;
  assign w_in_data[2] = csr_data;

  assign w_lsu_forced = r_full[1] && (r_lsu_cnt >= LIMIT);
  assign w_csr_forced = r_full[2] && (r_csr_cnt >= LIMIT);

  // Starved slots override the fixed ALU > LSU > CSR order, CSR checked first.
  always_comb begin
    w_gnt = 3'b000;
    if (w_csr_forced)      w_gnt = 3'b100;
    else if (w_lsu_forced) w_gnt = 3'b010;
    else if (r_full[0])    w_gnt = 3'b001;
    else if (r_full[1])    w_gnt = 3'b010;
    else if (r_full[2])    w_gnt = 3'b100;
  end

  assign w_ready   = ~r_full | w_gnt;
  assign alu_ready = w_ready[0];
  assign lsu_ready = w_ready[1];
  assign csr_ready = w_ready[2];

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_gnt[i]) begin
        w_sel_rd   = r_rd[i];
        w_sel_data = r_data[i];
      end
    end
  end

  // A grant drains the slot; an accept with rd != 0 refills it in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_gnt[i]) r_full[i] <= 1'b0;
        if (w_valid[i] && w_ready[i] && (w_in_rd[i] != 5'd0)) begin
          r_full[i] <= 1'b1;
          r_rd[i]   <= w_in_rd[i];
          r_data[i] <= w_in_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lsu_cnt <= '0;
      r_csr_cnt <= '0;
    end else begin
      if (r_full[1] && !w_gnt[1]) r_lsu_cnt <= (r_lsu_cnt == 4'hF) ? r_lsu_cnt : r_lsu_cnt + 4'd1;
      else                        r_lsu_cnt <= '0;
      if (r_full[2] && !w_gnt[2]) r_csr_cnt <= (r_csr_cnt == 4'hF) ? r_csr_cnt : r_csr_cnt + 4'd1;
      else                        r_csr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_we <= |w_gnt;
      if (|w_gnt) begin
        r_rd_addr <= w_sel_rd;
        r_rd_data <= w_sel_data;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < 3; i++) begin
      if (r_full[i]) w_pend[r_rd[i]] = 1'b1;
    end
    if (r_we) w_pend[r_rd_addr] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign rd_addr      = r_rd_addr;
  assign rd_data      = r_rd_data;
  assign rd_write_en  = r_we;
  assign pending_mask = w_pend;
  assign busy         = (|r_full) | r_we;

`ifdef CPU_WB_LOG_EN
`ifndef INFO
`define INFO(tag, msg) $display("%s: %s", tag, msg)
`endif
  always_ff @(posedge clk) begin
    if (!reset && |w_gnt) begin
      `INFO("cpu_writeback", $sformatf("t=%0t src=%s rd=x%0d data=0x%0h%s", $time,
            w_gnt[0] ? "alu" : (w_gnt[1] ? "lsu" : "csr"), w_sel_rd, w_sel_data,
            ((w_gnt[2] && w_csr_forced) || (w_gnt[1] && w_lsu_forced)) ? " forced" : ""));
    end
  end
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: directed scenarios plus random traffic against a slot-level reference model.
module tb_cpu_writeback;
  localparam int XLEN = 32;
  localparam int LIMIT = 4;
  localparam int W = 5 + XLEN;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            alu_valid = 0, lsu_valid = 0, csr_valid = 0;
  logic            alu_ready, lsu_ready, csr_ready;
  logic [4:0]      alu_rd = 0, lsu_rd = 0, csr_rd = 0;
  logic [XLEN-1:0] alu_data = 0, lsu_data = 0, csr_data = 0;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_write_en;
  logic [31:0]     pending_mask;
  logic            busy;

  int n_checks = 0;
  int n_bad = 0;
  bit mon_en = 0;

  cpu_writeback #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_rd(csr_rd), .csr_data(csr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
    .pending_mask(pending_mask), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: per-source buffered result plus count of lost cycles
  bit              m_full [3];
  logic [4:0]      m_rd   [3];
  logic [XLEN-1:0] m_data [3];
  int              m_wait [3];
  bit              m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_dout;
  logic [W-1:0]    exp_q[$];

  function automatic int model_pick();
    if (m_full[2] && m_wait[2] >= LIMIT) return 2;
    if (m_full[1] && m_wait[1] >= LIMIT) return 1;
    for (int s = 0; s < 3; s++) if (m_full[s]) return s;
    return -1;
  endfunction

  int              mg;
  bit              in_v [3];
  logic [4:0]      in_r [3];
  logic [XLEN-1:0] in_d [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin m_full[s] = 0; m_rd[s] = 0; m_data[s] = 0; m_wait[s] = 0; end
      m_we = 0; m_addr = 0; m_dout = 0;
      exp_q.delete();
    end else begin
      in_v[0] = alu_valid; in_r[0] = alu_rd; in_d[0] = alu_data;
      in_v[1] = lsu_valid; in_r[1] = lsu_rd; in_d[1] = lsu_data;
      in_v[2] = csr_valid; in_r[2] = csr_rd; in_d[2] = csr_data;
      mg = model_pick();
      m_we = (mg >= 0);
      if (mg >= 0) begin
        m_addr = m_rd[mg]; m_dout = m_data[mg];
        exp_q.push_back({m_rd[mg], m_data[mg]});
      end
      for (int s = 0; s < 3; s++) begin
        bit acc;
        acc = in_v[s] && (!m_full[s] || mg == s);
        m_wait[s] = (m_full[s] && mg != s) ? ((m_wait[s] < 15) ? m_wait[s] + 1 : 15) : 0;
        if (mg == s) m_full[s] = 0;
        if (acc && in_r[s] != 5'd0) begin m_full[s] = 1; m_rd[s] = in_r[s]; m_data[s] = in_d[s]; end
      end
    end
  end

  // scoreboard monitor, sampled mid-cycle
  int           sg;
  logic [31:0]  s_pm;
  logic [2:0]   s_rdy;
  logic [W-1:0] s_exp;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      sg = model_pick();
      s_pm = 0;
      for (int r = 1; r < 32; r++) begin
        for (int s = 0; s < 3; s++) if (m_full[s] && m_rd[s] == 5'(r)) s_pm[r] = 1'b1;
        if (m_we && m_addr == 5'(r)) s_pm[r] = 1'b1;
      end
      for (int s = 0; s < 3; s++) s_rdy[s] = !m_full[s] || sg == s;
      n_checks++;
      if ({csr_ready, lsu_ready, alu_ready} !== s_rdy) begin
        n_bad++; $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, {csr_ready, lsu_ready, alu_ready}, s_rdy);
      end
      n_checks++;
      if (rd_write_en !== m_we || rd_addr !== m_addr || rd_data !== m_dout) begin
        n_bad++; $display("FAIL mon_port t=%0t got=%b/%0d/%h exp=%b/%0d/%h", $time,
                          rd_write_en, rd_addr, rd_data, m_we, m_addr, m_dout);
      end
      n_checks++;
      if (pending_mask !== s_pm || busy !== (m_full[0] | m_full[1] | m_full[2] | m_we)) begin
        n_bad++; $display("FAIL mon_pend t=%0t got=%h/%b exp=%h", $time, pending_mask, busy, s_pm);
      end
      if (rd_write_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL mon_queue t=%0t got=write exp=no write", $time);
        end else begin
          s_exp = exp_q.pop_front();
          if ({rd_addr, rd_data} !== s_exp) begin
            n_bad++; $display("FAIL mon_order t=%0t got=%h exp=%h", $time, {rd_addr, rd_data}, s_exp);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 0; lsu_valid = 0; csr_valid = 0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rd_write_en !== 0 || rd_addr !== 0 || rd_data !== 0 || pending_mask !== 0 || busy !== 0) begin
      n_bad++; $display("FAIL reset_out got=%b/%0d/%h/%h/%b exp=0", rd_write_en, rd_addr, rd_data, pending_mask, busy);
    end
    reset = 0;
    mon_en = 1;
    @(negedge clk);
    n_checks++;
    if ({csr_ready, lsu_ready, alu_ready} !== 3'b111) begin
      n_bad++; $display("FAIL reset_ready got=%b exp=111", {csr_ready, lsu_ready, alu_ready});
    end
    next_cycle();
  endtask

  task automatic test_single();
    for (int c = 0; c < 4; c++) begin
      alu_valid = (c == 0); alu_rd = 5; alu_data = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready c=%0d got=%b exp=1", c, alu_ready); end
      n_checks++;
      if (pending_mask !== ((c == 1 || c == 2) ? 32'h20 : 32'h0)) begin
        n_bad++; $display("FAIL single_pend c=%0d got=%h", c, pending_mask);
      end
      n_checks++;
      if (rd_write_en !== (c == 2) || (c == 2 && (rd_addr !== 5 || rd_data !== 32'hDEADBEEF))) begin
        n_bad++; $display("FAIL single_commit c=%0d got=%b/%0d/%h exp we@2 x5=deadbeef", c, rd_write_en, rd_addr, rd_data);
      end
      next_cycle();
    end
    idle(2);
  endtask

  task automatic test_all_three();
    for (int c = 0; c < 6; c++) begin
      alu_valid = (c == 0); alu_rd = 1; alu_data = 32'h11;
      lsu_valid = (c == 0); lsu_rd = 2; lsu_data = 32'h22;
      csr_valid = (c == 0); csr_rd = 3; csr_data = 32'h33;
      @(negedge clk);
      n_checks++;
      if (lsu_ready !== (c != 1) || csr_ready !== !(c == 1 || c == 2)) begin
        n_bad++; $display("FAIL three_ready c=%0d got=%b%b", c, lsu_ready, csr_ready);
      end
      n_checks++;
      if (rd_write_en !== (c >= 2 && c <= 4) || (c >= 2 && c <= 4 && rd_addr !== 5'(c - 1))) begin
        n_bad++; $display("FAIL three_commit c=%0d got=%b/%0d exp x%0d", c, rd_write_en, rd_addr, c - 1);
      end
      next_cycle();
    end
    idle(2);
  endtask

  task automatic test_starve();
    for (int c = 0; c < 8; c++) begin
      alu_valid = 1; alu_rd = 7; alu_data = 32'(c);
      lsu_valid = (c == 0); lsu_rd = 8; lsu_data = 32'h88;
      @(negedge clk);
      if (c == 5) begin
        n_checks++;
        if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL starve_ready got=%b exp=0", alu_ready); end
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (rd_write_en !== 1'b1 || rd_addr !== 7 || rd_data !== 32'(c - 2)) begin
          n_bad++; $display("FAIL starve_alu c=%0d got=%b/%0d/%h", c, rd_write_en, rd_addr, rd_data);
        end
      end
      if (c == 6 || c == 7) begin
        n_checks++;
        if (rd_write_en !== 1'b1 || rd_addr !== ((c == 6) ? 5'd8 : 5'd7) ||
            rd_data !== ((c == 6) ? 32'h88 : 32'd4)) begin
          n_bad++; $display("FAIL starve_lsu c=%0d got=%b/%0d/%h", c, rd_write_en, rd_addr, rd_data);
        end
      end
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_rd_zero();
    for (int c = 0; c < 5; c++) begin
      csr_valid = (c == 0); csr_rd = 0; csr_data = 32'hFFFFFFFF;
      @(negedge clk);
      n_checks++;
      if (csr_ready !== 1'b1 || rd_write_en !== 1'b0 || pending_mask !== 0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rd_zero c=%0d got=%b/%b/%h/%b exp=1/0/0/0", c, csr_ready, rd_write_en, pending_mask, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      alu_valid = (c < 4); alu_rd = 5'(9 + c); alu_data = 32'(c * 3);
      @(negedge clk);
      n_checks++;
      if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, alu_ready); end
      n_checks++;
      if (rd_write_en !== (c >= 2) || (c >= 2 && rd_addr !== 5'(7 + c))) begin
        n_bad++; $display("FAIL b2b_commit c=%0d got=%b/%0d exp=x%0d", c, rd_write_en, rd_addr, 7 + c);
      end
      next_cycle();
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h66;
    next_cycle();
    alu_valid = 0; lsu_valid = 0;
    reset = 1;
    #1;
    n_checks++;
    if (rd_write_en !== 0 || rd_addr !== 0 || rd_data !== 0 || pending_mask !== 0 || busy !== 0) begin
      n_bad++; $display("FAIL midreset_out got=%b/%0d/%h/%h/%b exp=0", rd_write_en, rd_addr, rd_data, pending_mask, busy);
    end
    @(posedge clk); #1;
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (rd_write_en !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL midreset_after c=%0d got=%b/%b exp=0/0", c, rd_write_en, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 9) < 6); alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      lsu_valid = ($urandom_range(0, 9) < 5); lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
      csr_valid = ($urandom_range(0, 9) < 4); csr_rd = 5'($urandom_range(0, 31)); csr_data = $urandom;
      next_cycle();
    end
    idle(10);
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL random_drain got=%0d/%b exp=0/0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_starve();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Writeback arbiter that drives the register file's single write port (rd_addr, rd_data, rd_write_en).
- Collects results from three producers (ALU, load/store unit, CSR unit) over valid/ready handshakes and buffers one result per producer.
- Commits at most one write per cycle, with fixed priority plus anti-starvation.
- Exports a pending-destination mask that issue logic uses for hazard stalls.

Parameters:
- XLEN, 32, data width (32 or 64).
- STARVE_LIMIT, 4, consecutive lost arbitration cycles after which a lower-priority slot is forced to win (range 1..15).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU slot can accept
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- lsu_valid / lsu_ready / lsu_rd / lsu_data  as ALU, load/store unit
- csr_valid / csr_ready / csr_rd / csr_data  as ALU, CSR unit
- rd_addr  output  5  register file write address
- rd_data  output  XLEN  register file write data
- rd_write_en  output  1  register file write strobe
- pending_mask  output  32  bit i set if any buffered or committing result targets xi
- busy  output  1  any slot full or rd_write_en high

Behaviour:
- **Reset** (asynchronous, active-high): all slots empty; starvation counters 0; rd_addr=0, rd_data=0, rd_write_en=0; pending_mask=0; busy=0. Readies are 1 after reset. Reset mid-operation discards all buffered results; no write is issued.
- **Slots:** each source has a one-entry slot holding rd and data, plus a full flag.
  - src_ready = ~full | grant_src. Same-cycle drain and refill is allowed.
  - Accept on valid & ready at the clock edge; the slot loads rd and data, and full is set.
- **rd = 0:** a result with rd=0 is accepted (ready behaves normally) and dropped. It never sets full and never produces rd_write_en. The slot's prior state is unchanged.
- **Arbitration** (combinational, among full slots, evaluated each cycle):
  - If csr_cnt ≥ STARVE_LIMIT, grant CSR.
  - Else if lsu_cnt ≥ STARVE_LIMIT, grant LSU.
  - Else the fixed order ALU > LSU > CSR applies.
- **Starvation counters** (LSU and CSR only, 4 bits, saturating):
  - Increment each cycle the slot is full and not granted.
  - Clear on grant or when the slot is empty.
- **Commit:** at the edge after a grant, rd_addr/rd_data load the granted slot's contents and rd_write_en=1 for exactly one cycle; the granted slot's full flag clears. With no grant, rd_write_en=0, and rd_addr/rd_data hold their previous values.
- **Latency:** valid accepted at edge E0 → slot full in cycle 1 → rd_write_en high in cycle 2 when uncontended. The register file captures at the end of cycle 2.
- **Throughput:**
  - One commit per cycle.
  - A single source streaming every cycle sees ready continuously high.
  - With two or more sources contending, a losing source's ready stays low until its slot is granted.
- **pending_mask:** combinational OR of one-hot(rd) over all full slots, plus one-hot(rd_addr) when rd_write_en=1; bit 0 is always 0. A register pending in two places shows a single bit.
- **busy:** OR of the full flags and rd_write_en.
- **Ordering:** commits follow grant order; results are not reordered per register. Upstream must not have two in-flight results to the same rd, and uses pending_mask to enforce this. If this rule is violated, each write still commits exactly once, in grant order.

Optional Feature:
- Macro: CPU_WB_LOG_EN.
- Defined: on every commit, `INFO("cpu_writeback", ...) prints time, source name (alu/lsu/csr), rd index and data. A starvation-forced grant additionally prints a "forced" note.
- Undefined: no logging code is compiled; RTL behaviour is identical.

Test Plan:
1. alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle 0 only → cycle 2: rd_write_en=1, rd_addr=5, rd_data=0xDEADBEEF; pending_mask=0x20 in cycles 1–2, 0 in cycle 3; alu_ready=1 throughout.
2. All three valid in cycle 0 with rd=1/2/3, data 0x11/0x22/0x33 → commits in cycles 2, 3, 4 to x1, x2, x3; lsu_ready low in cycle 1; csr_ready low in cycles 1–2.
3. lsu_rd=8 accepted in cycle 0, ALU streaming rd=7 every cycle, STARVE_LIMIT=4 → LSU loses cycles 1–4 and commits x8 in cycle 6; ALU commits resume afterwards; alu_ready low in cycle 5.
4. csr_valid=1, csr_rd=0, csr_data=0xFFFFFFFF → csr_ready=1, no rd_write_en in cycles 1–4, pending_mask stays 0, busy stays 0.
5. ALU streaming rd=9..12 on consecutive cycles 0–3 → rd_write_en high in cycles 2–5 with addresses 9, 10, 11, 12; alu_ready never low.
6. Load the ALU and LSU slots, assert reset in cycle 1 for one cycle → rd_write_en, rd_addr, rd_data, pending_mask and busy are 0 immediately; no write occurs after reset release.
